// File: rtl/dsm_bridge_driver.sv
// H-bridge gate driver for the 3-level delta-sigma code: two identical legs with dead time,
// latched fault shutdown and an invalid-code monitor.
module dsm_bridge_driver #(
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             fault_i,
  input  logic [1:0]       pwm,
  output logic             hs_a,
  output logic             ls_a,
  output logic             hs_b,
  output logic             ls_b,
  output logic [1:0]       applied_o,
  output logic             fault_o,
  output logic             inv_o,
  output logic [CNT_W-1:0] inv_cnt
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             fault_reg;
  logic             inv_reg;
  logic [CNT_W-1:0] inv_cnt_reg;
  logic [1:0]       target_high;
  logic [1:0]       hs_v;
  logic [1:0]       ls_v;
  logic             shutdown;

  // Leg 0 is A (drives +1), leg 1 is B (drives -1); the invalid code 10 falls through to both LOW.
  assign target_high[0] = (pwm == 2'b01);
  assign target_high[1] = (pwm == 2'b11);
  assign shutdown       = !en || fault_i || fault_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_leg
      logic [1:0]       state_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg <= ST_OFF;
          cnt_reg   <= '0;
        end else if (shutdown) begin
          state_reg <= ST_OFF;
        end else begin
          case (state_reg)
            ST_OFF: begin
              state_reg <= ST_DEAD;
              cnt_reg   <= '0;
            end
            ST_LOW: begin
              if (target_high[gi]) begin
                state_reg <= ST_DEAD;
                cnt_reg   <= '0;
              end
            end
            ST_HIGH: begin
              if (!target_high[gi]) begin
                state_reg <= ST_DEAD;
                cnt_reg   <= '0;
              end
            end
            default: begin
              // Target is only looked at on the exit cycle, so glitches inside DEAD don't extend it.
              if (cnt_reg == DEAD_LAST)
                state_reg <= target_high[gi] ? ST_HIGH : ST_LOW;
              else
                cnt_reg <= cnt_reg + 1'b1;
            end
          endcase
        end
      end

      assign hs_v[gi] = (state_reg == ST_HIGH);
      assign ls_v[gi] = (state_reg == ST_LOW);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      fault_reg   <= 1'b0;
      inv_reg     <= 1'b0;
      inv_cnt_reg <= '0;
    end else begin
      if (fault_i)
        fault_reg <= 1'b1;
      inv_reg <= (pwm == 2'b10);
      if (pwm == 2'b10 && inv_cnt_reg != CNT_MAX)
        inv_cnt_reg <= inv_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    applied_o = 2'b10;
    if (hs_v[0] && ls_v[1])
      applied_o = 2'b01;
    else if (ls_v[0] && hs_v[1])
      applied_o = 2'b11;
    else if (ls_v[0] && ls_v[1])
      applied_o = 2'b00;
  end

  assign hs_a    = hs_v[0];
  assign ls_a    = ls_v[0];
  assign hs_b    = hs_v[1];
  assign ls_b    = ls_v[1];
  assign fault_o = fault_reg;
  assign inv_o   = inv_reg;
  assign inv_cnt = inv_cnt_reg;

endmodule

// File: tb/tb_dsm_bridge_driver.sv
// Directed bench for dsm_bridge_driver: the driver pushes hand-computed post-edge expectations,
// a negedge monitor pops and compares them.
module tb_dsm_bridge_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       fault_i = 1'b0;
  logic [1:0] pwm = 2'b00;
  logic       hs_a, ls_a, hs_b, ls_b;
  logic [1:0] applied_o;
  logic       fault_o, inv_o;
  logic [7:0] inv_cnt;

  typedef struct {
    logic [3:0] gates;   // {hs_a, ls_a, hs_b, ls_b}
    logic [1:0] app;
    logic       fo;
    logic       inv;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;
  bit         stim_done = 1'b0;

  dsm_bridge_driver #(.DEAD_CYCLES(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .en(en), .fault_i(fault_i), .pwm(pwm),
    .hs_a(hs_a), .ls_a(ls_a), .hs_b(hs_b), .ls_b(ls_b),
    .applied_o(applied_o), .fault_o(fault_o), .inv_o(inv_o), .inv_cnt(inv_cnt)
  );

  always #5 clock = ~clock;

  task automatic step(input logic r, input logic e, input logic f, input logic [1:0] p,
                      input logic [3:0] g, input logic [1:0] a, input logic fo,
                      input logic inv, input string nm);
    exp_t x;
    reset = r; en = e; fault_i = f; pwm = p;
    @(posedge clock);
    #1;
    x.gates = g; x.app = a; x.fo = fo; x.inv = inv; x.cnt = exp_cnt; x.name = nm;
    sb_q.push_back(x);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs depend only on registers, so the negedge sample is stable.
  initial begin
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        exp_t x;
        x = sb_q.pop_front();
        $display("txn %-10s gates=%b applied=%b fault=%b inv=%b cnt=%0d", x.name,
                 {hs_a, ls_a, hs_b, ls_b}, applied_o, fault_o, inv_o, inv_cnt);
        check({x.name, ".gates"}, {4'b0, hs_a, ls_a, hs_b, ls_b}, {4'b0, x.gates});
        check({x.name, ".applied"}, {6'b0, applied_o}, {6'b0, x.app});
        check({x.name, ".fault_o"}, {7'b0, fault_o}, {7'b0, x.fo});
        check({x.name, ".inv_o"}, {7'b0, inv_o}, {7'b0, x.inv});
        check({x.name, ".inv_cnt"}, inv_cnt, x.cnt);
        check({x.name, ".overlap"}, {6'b0, hs_a & ls_a, hs_b & ls_b}, 8'd0);
      end
    end
  end

  task automatic startup(input string nm);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b00, 4'b0000, 2'b10, 0, 0, {nm, "_dead"});
    step(0, 1, 0, 2'b00, 4'b0101, 2'b00, 0, 0, {nm, "_low"});
  endtask

  initial begin
    // 1: reset then startup through DEAD
    exp_cnt = 8'd0;
    step(1, 1, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "reset");
    step(1, 1, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "reset");
    startup("s1");
    step(0, 1, 0, 2'b00, 4'b0101, 2'b00, 0, 0, "s1_steady");

    // 2: 00 -> +1
    step(0, 1, 0, 2'b01, 4'b0001, 2'b10, 0, 0, "s2_dead");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2'b01, 4'b0001, 2'b10, 0, 0, "s2_dead");
    step(0, 1, 0, 2'b01, 4'b1001, 2'b01, 0, 0, "s2_plus");
    step(0, 1, 0, 2'b01, 4'b1001, 2'b01, 0, 0, "s2_plus");

    // 3: +1 -> -1, both legs dead together
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b11, 4'b0000, 2'b10, 0, 0, "s3_dead");
    step(0, 1, 0, 2'b11, 4'b0110, 2'b11, 0, 0, "s3_minus");

    // back to 00, then a one-cycle +1 glitch
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b00, 4'b0100, 2'b10, 0, 0, "s4_bdead");
    step(0, 1, 0, 2'b00, 4'b0101, 2'b00, 0, 0, "s4_zero");
    step(0, 1, 0, 2'b01, 4'b0001, 2'b10, 0, 0, "s4_glitch");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2'b00, 4'b0001, 2'b10, 0, 0, "s4_dead");
    step(0, 1, 0, 2'b00, 4'b0101, 2'b00, 0, 0, "s4_zero");

    // 5: fault from +1, sticky until reset
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b01, 4'b0001, 2'b10, 0, 0, "s5_dead");
    step(0, 1, 0, 2'b01, 4'b1001, 2'b01, 0, 0, "s5_plus");
    step(0, 1, 1, 2'b01, 4'b0000, 2'b10, 1, 0, "s5_fault");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2'b01, 4'b0000, 2'b10, 1, 0, "s5_sticky");
    step(1, 1, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "s5_reset");
    startup("s5");

    // 6: 300 invalid codes, counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      if (exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
      step(0, 1, 0, 2'b10, 4'b0101, 2'b00, 0, 1, "s6_inv");
    end
    step(0, 1, 0, 2'b00, 4'b0101, 2'b00, 0, 0, "s6_valid");

    // en falling, then restart
    step(0, 0, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "en_off");
    step(0, 0, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "en_off");
    startup("en_on");

    // fault on the DEAD exit edge wins
    step(0, 0, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "fx_off");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "fx_dead");
    step(0, 1, 1, 2'b00, 4'b0000, 2'b10, 1, 0, "fx_exit");
    exp_cnt = 8'd0;
    step(1, 1, 0, 2'b00, 4'b0000, 2'b10, 0, 0, "fx_reset");
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 5000;
    wait (stim_done);
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    @(posedge clock);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
